// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Latency WIDTH cycles from the accepting edge; start is ignored while busy.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = 4 * DIGITS;
  localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;
  localparam longint unsigned BCD_CAP = 64'd10 ** DIGITS;

  if (WIDTH < 1) begin : g_width_chk
    $error("bin2bcd_seq: WIDTH must be >= 1");
  end
  if (BCD_CAP <= MAX_BIN) begin : g_digits_chk
    $error("bin2bcd_seq: DIGITS too small to hold 2**WIDTH-1");
  end

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                r_state, w_state_nxt;
  logic [WIDTH-1:0]      r_shift, w_shift_nxt;
  logic [DW-1:0]         r_digits, w_digits_nxt;
  logic [DW-1:0]         r_bcd, w_bcd_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  r_done, w_done_nxt;
  logic [DW-1:0]         w_corr;
  logic [DW+WIDTH-1:0]   w_cat;

  // Add-3 correction; codes 10..15 never occur from a legal start, so they collapse to 0.
  always_comb begin
    w_corr = '0;
    for (int i = 0; i < DIGITS; i++) begin
      case (r_digits[4*i +: 4])
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4: w_corr[4*i +: 4] = r_digits[4*i +: 4];
        4'd5, 4'd6, 4'd7, 4'd8, 4'd9: w_corr[4*i +: 4] = r_digits[4*i +: 4] + 4'd3;
        default:                      w_corr[4*i +: 4] = 4'd0;
      endcase
    end
    w_cat = {w_corr, r_shift} << 1;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_digits_nxt = r_digits;
    w_bcd_nxt    = r_bcd;
    w_cnt_nxt    = r_cnt;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_shift_nxt  = bin_in;
          w_digits_nxt = '0;
          w_cnt_nxt    = CW'(WIDTH);
          w_state_nxt  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift_nxt  = w_cat[WIDTH-1:0];
        w_digits_nxt = w_cat[DW+WIDTH-1:WIDTH];
        w_cnt_nxt    = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_bcd_nxt   = w_cat[DW+WIDTH-1:WIDTH];
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_digits <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_digits <= w_digits_nxt;
      r_bcd    <= w_bcd_nxt;
      r_cnt    <= w_cnt_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign ready   = (r_state == S_IDLE);
  assign busy    = ~ready;
  assign done    = r_done;
  assign bcd_out = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: 8-bit and 16-bit instances checked each cycle against a
// decimal-arithmetic model, plus directed literal cases and an exhaustive 8-bit sweep.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start8, start16;
  logic [7:0]  bin8;
  logic [15:0] bin16;
  logic        rdy8, bsy8, dn8;
  logic        rdy16, bsy16, dn16;
  logic [11:0] bcd8;
  logic [19:0] bcd16;

  int n_vec = 0;
  int n_err = 0;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .bin_in(bin8),
    .ready(rdy8), .busy(bsy8), .done(dn8), .bcd_out(bcd8)
  );

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .bin_in(bin16),
    .ready(rdy16), .busy(bsy16), .done(dn16), .bcd_out(bcd16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a conversion is just a countdown of WIDTH cycles followed by decimal digits.
  int          m8_rem, m16_rem;
  int unsigned m8_val, m16_val;
  logic        m8_done, m16_done;
  logic [11:0] m8_bcd;
  logic [19:0] m16_bcd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_rem = 0; m8_done = 1'b0; m8_bcd = '0; m8_val = 0;
      m16_rem = 0; m16_done = 1'b0; m16_bcd = '0; m16_val = 0;
    end else begin
      m8_done = 1'b0;
      if (m8_rem > 0) begin
        m8_rem--;
        if (m8_rem == 0) begin
          m8_done = 1'b1;
          m8_bcd  = to_bcd(m8_val) & 20'h00FFF;
        end
      end else if (start8) begin
        m8_val = bin8;
        m8_rem = 8;
      end
      m16_done = 1'b0;
      if (m16_rem > 0) begin
        m16_rem--;
        if (m16_rem == 0) begin
          m16_done = 1'b1;
          m16_bcd  = to_bcd(m16_val);
        end
      end else if (start16) begin
        m16_val = bin16;
        m16_rem = 16;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("rdy8",  rdy8,  m8_rem == 0);
    chk("bsy8",  bsy8,  m8_rem != 0);
    chk("done8", dn8,   m8_done);
    chk("bcd8",  bcd8,  m8_bcd);
    chk("rdy16", rdy16, m16_rem == 0);
    chk("bsy16", bsy16, m16_rem != 0);
    chk("done16", dn16, m16_done);
    chk("bcd16", bcd16, m16_bcd);
    for (int i = 0; i < 3; i++)
      if (dut8.r_digits[4*i +: 4] > 4'd9) begin
        n_err++;
        $display("FAIL digit8[%0d]: got %h expected <= 9", i, dut8.r_digits[4*i +: 4]);
      end
    for (int i = 0; i < 5; i++)
      if (dut16.r_digits[4*i +: 4] > 4'd9) begin
        n_err++;
        $display("FAIL digit16[%0d]: got %h expected <= 9", i, dut16.r_digits[4*i +: 4]);
      end
  end

  // Called one step after a rising edge with the target instance idle.
  task automatic conv(input bit w, input int unsigned v, input logic [19:0] exp, input string nm);
    int cyc;
    bit got;
    if (w) begin start16 = 1'b1; bin16 = v[15:0]; end
    else   begin start8  = 1'b1; bin8  = v[7:0];  end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    bin8 = 8'($urandom); bin16 = 16'($urandom);
    got = 1'b0; cyc = 0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      got = w ? dn16 : dn8;
    end
    chk({nm, "_lat"}, cyc, w ? 16 : 8);
    chk({nm, "_val"}, w ? {12'h0, bcd16} : {20'h0, bcd8}, {12'h0, exp});
    @(posedge clk); #1;
    chk({nm, "_dlow"}, w ? dn16 : dn8, 0);
  endtask

  initial begin
    int cyc, ndone;
    rst_n = 1'b0; start8 = 1'b0; start16 = 1'b0; bin8 = '0; bin16 = '0;
    #12;
    chk("rst_rdy", rdy8, 1); chk("rst_bsy", bsy8, 0);
    chk("rst_done", dn8, 0); chk("rst_bcd", bcd8, 0);
    chk("rst_bcd16", bcd16, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    conv(0, 255, 20'h00255, "ff");
    conv(0, 0,   20'h00000, "zero");
    conv(0, 99,  20'h00099, "n99");
    conv(0, 100, 20'h00100, "n100");
    conv(1, 65535, 20'h65535, "w16max");
    conv(1, 10000, 20'h10000, "w16_1e4");

    // Start held high through the busy window must not launch a second conversion.
    start8 = 1'b1; bin8 = 8'd200;
    @(posedge clk); #1; bin8 = 8'd45;
    ndone = 0;
    for (int i = 1; i < 8; i++) begin @(posedge clk); #1; if (dn8) ndone++; end
    start8 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (dn8) begin ndone++; chk("hold_val", bcd8, 12'h200); end
    end
    chk("hold_ndone", ndone, 1);

    // Back-to-back: second start issued in the done cycle.
    start8 = 1'b1; bin8 = 8'd17;
    @(posedge clk); #1; start8 = 1'b0;
    cyc = 0;
    while (!dn8 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("b2b_lat1", cyc, 8); chk("b2b_val1", bcd8, 12'h017);
    start8 = 1'b1; bin8 = 8'd250;
    @(posedge clk); #1; start8 = 1'b0;
    chk("b2b_busy", bsy8, 1);
    cyc = 0;
    while (!dn8 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (!dn8) chk("b2b_hold", bcd8, 12'h017);
    end
    chk("b2b_lat2", cyc, 8); chk("b2b_val2", bcd8, 12'h250);

    // Reset during a conversion aborts it without a done pulse.
    @(posedge clk); #1;
    start8 = 1'b1; bin8 = 8'd123;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_rdy", rdy8, 1); chk("abort_bcd", bcd8, 0); chk("abort_done", dn8, 0);
    #1 rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (dn8) ndone++; end
    chk("abort_ndone", ndone, 0);
    conv(0, 9, 20'h00009, "after_rst");

    for (int v = 0; v < 256; v++) conv(0, v, to_bcd(v), "sweep");

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start8  = ($urandom_range(2) == 0);
      start16 = ($urandom_range(2) == 0);
      bin8    = 8'($urandom);
      bin16   = 16'($urandom);
      if ($urandom_range(399) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    start8 = 1'b0; start16 = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
